// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light safety monitor: lamp aspects,
// fault codes and the monitor state enum.
package traffic_pkg;

  localparam logic [3:0] CAR_RED    = 4'b1000;
  localparam logic [3:0] CAR_YELLOW = 4'b0100;
  localparam logic [3:0] CAR_LEFT   = 4'b0010;
  localparam logic [3:0] CAR_GREEN  = 4'b0001;
  localparam logic [3:0] CAR_DARK   = 4'b0000;

  localparam logic [1:0] WALK_RED   = 2'b10;
  localparam logic [1:0] WALK_GREEN = 2'b01;
  localparam logic [1:0] WALK_OFF   = 2'b00;
  localparam logic [1:0] WALK_BAD   = 2'b11;

  localparam logic [2:0] FAULT_NONE     = 3'd0;
  localparam logic [2:0] FAULT_ONEHOT   = 3'd1;
  localparam logic [2:0] FAULT_WALK     = 3'd2;
  localparam logic [2:0] FAULT_CONFLICT = 3'd3;
  localparam logic [2:0] FAULT_ORDER    = 3'd4;
  localparam logic [2:0] FAULT_DWELL    = 3'd5;
  localparam logic [2:0] FAULT_SHORT    = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} mon_state_e;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/traffic_if.sv
// Controller-to-lamp bus: raw aspects and clear request from the controller,
// supervised aspects and fault status back out of the monitor.
interface traffic_if #(
  parameter int CNT_W = 7
);
  logic [3:0]       car_traffic;
  logic [1:0]       walk_traffic;
  logic             clear_fault;
  logic [3:0]       safe_car;
  logic [1:0]       safe_walk;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] phase_cnt;
  logic [15:0]      cycle_count;

  modport master (
    output car_traffic, walk_traffic, clear_fault,
    input  safe_car, safe_walk, fault, fault_code, phase_cnt, cycle_count
  );

  modport slave (
    input  car_traffic, walk_traffic, clear_fault,
    output safe_car, safe_walk, fault, fault_code, phase_cnt, cycle_count
  );
endinterface

// File: rtl/traffic_blink.sv
// Fault-mode blink generator: lamp_on toggles every BLINK_CYC cycles and is
// forced on, with the count restarted, by the start pulse.
module traffic_blink #(
  parameter int BLINK_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic lamp_on
);
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BW-1:0] cnt;

  // half-period counter and lamp phase
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      lamp_on <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      lamp_on <= 1'b1;
    end else if (cnt == BW'(BLINK_CYC - 1)) begin
      cnt     <= '0;
      lamp_on <= ~lamp_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/traffic_monitor.sv
// Safety monitor between the traffic controller and the lamp drivers.
// Samples the aspects once, checks encoding/conflict/order/dwell, and on the
// first violation latches a fault code and shows a blinking-yellow fail-safe.
// Optional feature: define TRAFFIC_MON_STATS_EN to count completed
// RED->GREEN cycles on cycle_count; otherwise cycle_count is tied to zero.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int GREEN_MAX  = 21,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 3,
  parameter int LEFT_MAX   = 11,
  parameter int RED_MAX    = 35,
  parameter int BLINK_CYC  = 8
) (
  input logic      clk,
  input logic      rst,
  traffic_if.slave mon
);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  mon_state_e       state, state_nxt;
  logic [3:0]       car_p0, car_p1;
  logic [1:0]       walk_p0, walk_p1;
  logic             clr_p0;
  logic             yellow_from_left;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       code_q, code_nxt;
  logic             chg, sample_ok, lamp_on, blink_start;
  logic [3:0]       car_lamp;
  logic [1:0]       walk_lamp;
  logic             fault_flag;

  function automatic logic [CNT_W-1:0] dwell_max(input logic [3:0] car);
    case (car)
      CAR_GREEN:  return CNT_W'(GREEN_MAX);
      CAR_YELLOW: return CNT_W'(YELLOW_MAX);
      CAR_LEFT:   return CNT_W'(LEFT_MAX);
      CAR_RED:    return CNT_W'(RED_MAX);
      default:    return CNT_SAT;
    endcase
  endfunction

  function automatic logic order_ok(input logic [3:0] prv, input logic [3:0] cur,
                                    input logic from_left);
    case (prv)
      CAR_GREEN:  return cur == CAR_YELLOW;
      CAR_YELLOW: return from_left ? (cur == CAR_RED) : (cur == CAR_LEFT);
      CAR_LEFT:   return cur == CAR_YELLOW;
      CAR_RED:    return cur == CAR_GREEN;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  // p0: raw inputs sampled; p1: last accepted aspect, also the previous phase
  always_ff @(posedge clk) begin
    car_p0  <= mon.car_traffic;
    walk_p0 <= mon.walk_traffic;
    if (state_nxt == ST_RUN) begin
      car_p1  <= car_p0;
      walk_p1 <= walk_p0;
    end
  end

  // violation checks on the p0 sample; lowest nonzero code wins
  always_comb begin
    chg       = (car_p0 != car_p1);
    cnt_nxt   = chg ? CNT_W'(1) : sat_inc(cnt_q);
    sample_ok = is_onehot(car_p0) && (walk_p0 != WALK_BAD);
    if (!is_onehot(car_p0))
      code_nxt = FAULT_ONEHOT;
    else if (walk_p0 == WALK_BAD)
      code_nxt = FAULT_WALK;
    else if ((walk_p0 != WALK_RED) && (car_p0 != CAR_RED))
      code_nxt = FAULT_CONFLICT;
    else if (chg && !order_ok(car_p1, car_p0, yellow_from_left))
      code_nxt = FAULT_ORDER;
    else if (cnt_nxt > dwell_max(car_p0))
      code_nxt = FAULT_DWELL;
    else if (chg && (car_p1 == CAR_YELLOW) && (cnt_q < CNT_W'(YELLOW_MIN)))
      code_nxt = FAULT_SHORT;
    else
      code_nxt = FAULT_NONE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sample_ok) state_nxt = ST_RUN;
      ST_RUN:   if (code_nxt != FAULT_NONE) state_nxt = ST_FAULT;
      ST_FAULT: if (clr_p0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // control registers: clear request, dwell count, yellow origin, fault code
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_p0           <= 1'b0;
      cnt_q            <= '0;
      code_q           <= FAULT_NONE;
      yellow_from_left <= 1'b0;
    end else begin
      clr_p0 <= mon.clear_fault;
      case (state)
        ST_IDLE: if (state_nxt == ST_RUN) begin
          cnt_q            <= CNT_W'(1);
          yellow_from_left <= 1'b0;
        end
        ST_RUN: begin
          cnt_q <= cnt_nxt;
          if (chg && (car_p0 == CAR_YELLOW)) yellow_from_left <= (car_p1 == CAR_LEFT);
          if (state_nxt == ST_FAULT) code_q <= code_nxt;
        end
        ST_FAULT: if (state_nxt == ST_IDLE) begin
          cnt_q  <= '0;
          code_q <= FAULT_NONE;
        end
        default: ;
      endcase
    end
  end

  assign blink_start = (state == ST_RUN) && (state_nxt == ST_FAULT);

  traffic_blink #(.BLINK_CYC(BLINK_CYC)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .start   (blink_start),
    .lamp_on (lamp_on)
  );

  // output decode: reset aspect when idle, forwarded aspect when running
  always_comb begin
    car_lamp   = CAR_RED;
    walk_lamp  = WALK_RED;
    fault_flag = 1'b0;
    case (state)
      ST_RUN: begin
        car_lamp  = car_p1;
        walk_lamp = walk_p1;
      end
      ST_FAULT: begin
        car_lamp   = lamp_on ? CAR_YELLOW : CAR_DARK;
        fault_flag = 1'b1;
      end
      default: ;
    endcase
  end

  assign mon.safe_car   = car_lamp;
  assign mon.safe_walk  = walk_lamp;
  assign mon.fault      = fault_flag;
  assign mon.fault_code = code_q;
  assign mon.phase_cnt  = cnt_q;

`ifdef TRAFFIC_MON_STATS_EN
  logic [15:0] cyc_q;

  // completed RED->GREEN cycles, counted only while the monitor stays in RUN
  always_ff @(posedge clk) begin
    if (rst)
      cyc_q <= 16'd0;
    else if ((state == ST_RUN) && (state_nxt == ST_RUN) && chg &&
             (car_p1 == CAR_RED) && (car_p0 == CAR_GREEN))
      cyc_q <= cyc_q + 16'd1;
  end

  assign mon.cycle_count = cyc_q;
`else
  assign mon.cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_traffic_monitor.sv
// Testbench for traffic_monitor: scenario tasks push expected outputs into a
// scoreboard queue as stimulus is applied and compare two cycles later.
module tb_traffic_monitor;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_if #(.CNT_W(7)) bus();

  traffic_monitor #(.CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  typedef struct {
    logic [3:0] car;
    logic [1:0] walk;
    logic       flt;
    logic [2:0] code;
    int         cnt;
  } exp_t;

  typedef struct {
    logic [3:0] car;
    logic [1:0] walk;
    logic       clr;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t ex(input logic [3:0] c, input logic [1:0] w, input logic f,
                              input logic [2:0] code, input int n);
    exp_t e;
    e.car = c; e.walk = w; e.flt = f; e.code = code; e.cnt = n;
    return e;
  endfunction

  function automatic vec_t vec(input logic [3:0] c, input logic [1:0] w, input logic clr,
                               input exp_t e);
    vec_t v;
    v.car = c; v.walk = w; v.clr = clr; v.e = e;
    return v;
  endfunction

  function automatic logic [3:0] blink_car(input int j);
    return (((j / 8) % 2) == 0) ? CAR_YELLOW : CAR_DARK;
  endfunction

  function automatic exp_t idle_ex();
    return ex(CAR_RED, WALK_RED, 1'b0, FAULT_NONE, 0);
  endfunction

  function automatic exp_t run_ex(input logic [3:0] c, input logic [1:0] w, input int n);
    return ex(c, w, 1'b0, FAULT_NONE, n);
  endfunction

  function automatic exp_t flt_ex(input logic [2:0] code, input int j, input int n);
    return ex(blink_car(j), WALK_RED, 1'b1, code, n);
  endfunction

  task automatic drive(input vec_t v);
    bus.car_traffic  = v.car;
    bus.walk_traffic = v.walk;
    bus.clear_fault  = v.clr;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.car_traffic  = CAR_DARK;
    bus.walk_traffic = WALK_RED;
    bus.clear_fault  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t e;
    apply_reset();
    total++;
    if ({bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code} !== {CAR_RED, WALK_RED, 1'b0, FAULT_NONE}) begin
      bad++;
      $display("FAIL reset_aspect: got car=%b walk=%b fault=%b code=%0d, want 1000 10 0 0",
               bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code);
    end
    total++;
    if (bus.phase_cnt !== 7'd0 || bus.cycle_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_counts: got phase_cnt=%0d cycle_count=%0d, want 0 0", bus.phase_cnt, bus.cycle_count);
    end
    v.push_back(vec(4'b0110, WALK_RED, 1'b0, idle_ex()));
    v.push_back(vec(4'b0110, WALK_RED, 1'b1, idle_ex()));
    v.push_back(vec(CAR_RED, WALK_BAD, 1'b0, idle_ex()));
    v.push_back(vec(CAR_RED, WALK_BAD, 1'b0, idle_ex()));
    v.push_back(vec(CAR_DARK, WALK_RED, 1'b0, idle_ex()));
    for (int k = 1; k <= 3; k++) v.push_back(vec(CAR_RED, WALK_GREEN, 1'b0, run_ex(CAR_RED, WALK_GREEN, k)));
    foreach (v[i]) begin
      drive(v[i]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
            bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL idle step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                   i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
        end
      end
    end
  endtask

  task automatic test_legal();
    vec_t       v[$];
    exp_t       e;
    logic [3:0] ph_car [5];
    int         ph_len [5];
    logic [1:0] w;
    logic [15:0] exp_cyc;
    ph_car = '{CAR_GREEN, CAR_YELLOW, CAR_LEFT, CAR_YELLOW, CAR_RED};
    ph_len = '{21, 3, 11, 3, 35};
    apply_reset();
    for (int rep = 0; rep < 3; rep++)
      for (int p = 0; p < 5; p++)
        for (int k = 1; k <= ph_len[p]; k++) begin
          w = (p == 4) ? WALK_GREEN : WALK_RED;
          v.push_back(vec(ph_car[p], w, 1'b0, run_ex(ph_car[p], w, k)));
        end
    for (int k = 1; k <= 3; k++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, k)));
    foreach (v[i]) begin
      drive(v[i]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
            bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL legal step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                   i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
        end
      end
    end
`ifdef TRAFFIC_MON_STATS_EN
    exp_cyc = 16'd3;
`else
    exp_cyc = 16'd0;
`endif
    total++;
    if (bus.cycle_count !== exp_cyc) begin
      bad++;
      $display("FAIL legal_cycle_count: got %0d, want %0d", bus.cycle_count, exp_cyc);
    end
  endtask

  // continues from the running state left by test_legal
  task automatic test_rst_fault();
    vec_t v[$];
    exp_t e;
    for (int j = 0; j <= 11; j++) v.push_back(vec(4'b0110, WALK_RED, 1'b0, flt_ex(FAULT_ONEHOT, j, -1)));
    foreach (v[i]) begin
      drive(v[i]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
            bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL rst_fault step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                   i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
        end
      end
    end
    rst = 1'b1;
    bus.clear_fault = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code} !== {CAR_RED, WALK_RED, 1'b0, FAULT_NONE}) begin
      bad++;
      $display("FAIL rst_mid_fault_aspect: got car=%b walk=%b fault=%b code=%0d, want 1000 10 0 0",
               bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code);
    end
    total++;
    if (bus.phase_cnt !== 7'd0 || bus.cycle_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_fault_counts: got phase_cnt=%0d cycle_count=%0d, want 0 0", bus.phase_cnt, bus.cycle_count);
    end
    bus.clear_fault = 1'b0;
  endtask

  task automatic test_onehot();
    vec_t v[$];
    exp_t e;
    apply_reset();
    for (int k = 1; k <= 5; k++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, k)));
    for (int j = 0; j <= 19; j++) v.push_back(vec(4'b0110, WALK_GREEN, 1'b0, flt_ex(FAULT_ONEHOT, j, -1)));
    foreach (v[i]) begin
      drive(v[i]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
            bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL onehot step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                   i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
        end
      end
    end
  endtask

  // run 0: GREEN->LEFT direct; run 1: YELLOW entered from GREEN then RED
  // run 2: walk GREEN under car GREEN; run 3: same plus bad order, conflict wins
  task automatic test_order_conflict();
    vec_t v[$];
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      v.delete();
      for (int k = 1; k <= 3; k++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, k)));
      case (r)
        0: v.push_back(vec(CAR_LEFT, WALK_RED, 1'b0, flt_ex(FAULT_ORDER, 0, -1)));
        1: begin
          for (int k = 1; k <= 2; k++) v.push_back(vec(CAR_YELLOW, WALK_RED, 1'b0, run_ex(CAR_YELLOW, WALK_RED, k)));
          v.push_back(vec(CAR_RED, WALK_RED, 1'b0, flt_ex(FAULT_ORDER, 0, -1)));
        end
        2: v.push_back(vec(CAR_GREEN, WALK_GREEN, 1'b0, flt_ex(FAULT_CONFLICT, 0, -1)));
        default: v.push_back(vec(CAR_LEFT, WALK_GREEN, 1'b0, flt_ex(FAULT_CONFLICT, 0, -1)));
      endcase
      for (int j = 1; j <= 3; j++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, flt_ex(r < 2 ? FAULT_ORDER : FAULT_CONFLICT, j, -1)));
      foreach (v[i]) begin
        drive(v[i]);
        if (sb.size() > 1) begin
          e = sb.pop_front();
          total++;
          if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
              bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
            bad++;
            $display("FAIL order_conflict run %0d step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                     r, i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
          end
        end
      end
    end
  endtask

  // run 0: GREEN held 22 cycles; run 1: YELLOW held 1 cycle
  task automatic test_dwell();
    vec_t v[$];
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      v.delete();
      if (r == 0) begin
        for (int k = 1; k <= 21; k++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, k)));
        for (int j = 0; j <= 3; j++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, flt_ex(FAULT_DWELL, j, 22)));
      end else begin
        for (int k = 1; k <= 3; k++) v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, k)));
        v.push_back(vec(CAR_YELLOW, WALK_RED, 1'b0, run_ex(CAR_YELLOW, WALK_RED, 1)));
        for (int j = 0; j <= 3; j++) v.push_back(vec(CAR_LEFT, WALK_RED, 1'b0, flt_ex(FAULT_SHORT, j, 1)));
      end
      foreach (v[i]) begin
        drive(v[i]);
        if (sb.size() > 1) begin
          e = sb.pop_front();
          total++;
          if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
              bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
            bad++;
            $display("FAIL dwell run %0d step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                     r, i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
          end
        end
      end
    end
  endtask

  task automatic test_clear();
    vec_t v[$];
    exp_t e;
    apply_reset();
    v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, 1)));
    v.push_back(vec(CAR_GREEN, WALK_RED, 1'b1, run_ex(CAR_GREEN, WALK_RED, 2)));
    v.push_back(vec(CAR_GREEN, WALK_RED, 1'b0, run_ex(CAR_GREEN, WALK_RED, 3)));
    for (int j = 0; j <= 2; j++) v.push_back(vec(4'b0110, WALK_RED, 1'b0, flt_ex(FAULT_ONEHOT, j, -1)));
    v.push_back(vec(4'b0110, WALK_RED, 1'b1, idle_ex()));
    v.push_back(vec(CAR_DARK, WALK_RED, 1'b0, idle_ex()));
    for (int k = 1; k <= 3; k++) v.push_back(vec(CAR_RED, WALK_GREEN, 1'b0, run_ex(CAR_RED, WALK_GREEN, k)));
    foreach (v[i]) begin
      drive(v[i]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if (bus.safe_car !== e.car || bus.safe_walk !== e.walk || bus.fault !== e.flt ||
            bus.fault_code !== e.code || (e.cnt >= 0 && bus.phase_cnt !== 7'(e.cnt))) begin
          bad++;
          $display("FAIL clear step %0d: got car=%b walk=%b fault=%b code=%0d cnt=%0d, want car=%b walk=%b fault=%b code=%0d cnt=%0d",
                   i, bus.safe_car, bus.safe_walk, bus.fault, bus.fault_code, bus.phase_cnt, e.car, e.walk, e.flt, e.code, e.cnt);
        end
      end
    end
  endtask

  initial begin
    bus.car_traffic  = CAR_DARK;
    bus.walk_traffic = WALK_RED;
    bus.clear_fault  = 1'b0;
    test_reset();
    test_legal();
    test_rst_fault();
    test_onehot();
    test_order_conflict();
    test_dwell();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
